// File: rtl/imem_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words, fills instruction
// memory from BASE_WORD upward, then releases the core with the start PC from the stream header.
module imem_loader #(
   parameter int unsigned       ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [31:0]       start_pc,
   output logic              core_run,
   output logic [ADDR_W:0]   word_count,
   output logic              error
);

   typedef enum logic [1:0] {StHdr, StLoad, StRun, StErr} state_e;

   state_e      state_q;
   logic [1:0]  idx_q;
   logic [31:0] asm_q;
   logic        accept;
   logic        mem_full;
   logic [31:0] word_next;

   // Only the two receiving states take bytes; held low while in reset.
   assign in_ready  = rst_n & ((state_q == StHdr) | (state_q == StLoad));
   assign accept    = in_valid & in_ready;
   assign word_next = {asm_q[23:0], in_data};
   assign mem_full  = (word_count == {1'b1, {ADDR_W{1'b0}}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StHdr;
         idx_q      <= 2'd0;
         asm_q      <= 32'd0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_WORD;
         imem_wdata <= 32'd0;
         start_pc   <= 32'd0;
         core_run   <= 1'b0;
         word_count <= '0;
         error      <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state_q)
            StHdr: begin
               if (accept) begin
                  start_pc <= {start_pc[23:0], in_data};
                  idx_q    <= idx_q + 2'd1;
                  if (in_last) begin
                     state_q <= StErr;
                     error   <= 1'b1;
                  end else if (idx_q == 2'd3) begin
                     state_q <= StLoad;
                  end
               end
            end
            StLoad: begin
               if (accept) begin
                  asm_q <= word_next;
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     if (mem_full) begin
                        state_q <= StErr;
                        error   <= 1'b1;
                     end else begin
                        // Address wraps naturally in ADDR_W bits; capacity is tracked by word_count.
                        imem_we    <= 1'b1;
                        imem_wdata <= word_next;
                        imem_addr  <= BASE_WORD + word_count[ADDR_W-1:0];
                        word_count <= word_count + 1'b1;
                        if (in_last) begin
                           state_q  <= StRun;
                           core_run <= 1'b1;
                        end
                     end
                  end else if (in_last) begin
                     state_q <= StErr;
                     error   <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
